// File: rtl/nn_parameters.sv
// Shared classifier-output parameters and types.
// Used by softmax_decision and decision_stability_filter.
package nn_parameters;

    localparam int NN_OUT_SIZE   = 4;
    localparam int NN_PROB_W     = 16;
    localparam int NN_STABLE_CNT = 3;
    localparam int NN_ID_W       = $clog2(NN_OUT_SIZE + 1);

    localparam logic [NN_PROB_W-1:0] NN_CONF_THRESH = 16'h4000;
    localparam logic [NN_PROB_W-1:0] NN_MARGIN      = 16'h1000;

    localparam logic [NN_ID_W-1:0] NO_CLASS = NN_ID_W'(NN_OUT_SIZE);

    typedef logic [NN_PROB_W-1:0] prob_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DECIDE,
        S_OUT
    } state_t;

endpackage

// File: rtl/decision_stability_filter.sv
// Consecutive-decision stability filter.
// Tracks last accepted id and a saturating repeat counter.
module decision_stability_filter
    import nn_parameters::*;
#(
    parameter int ID_W       = NN_ID_W,
    parameter int STABLE_CNT = NN_STABLE_CNT,
    parameter logic [ID_W-1:0] NOCLS = ID_W'(NN_OUT_SIZE)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_en,
    input  logic            i_reject,
    input  logic [ID_W-1:0] i_id,
    output logic            o_stable
);

    localparam logic [3:0] L_STABLE = 4'(STABLE_CNT);

    logic [3:0]      r_cnt;
    logic [ID_W-1:0] r_last;
    logic            r_stable;
    logic [3:0]      w_cnt;
    logic [ID_W-1:0] w_last;

    // Next counter and last-id values for this decision.
    always_comb begin
        w_cnt  = r_cnt;
        w_last = i_reject ? NOCLS : i_id;
        if (i_reject) begin
            w_cnt = 4'd0;
        end else if (i_id == r_last) begin
            if (r_cnt < L_STABLE) begin
                w_cnt = r_cnt + 4'd1;
            end
        end else begin
            w_cnt = 4'd1;
        end
    end

    // Commit filter state once per decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= 4'd0;
            r_last   <= NOCLS;
            r_stable <= 1'b0;
        end else if (i_en) begin
            r_cnt    <= w_cnt;
            r_last   <= w_last;
            r_stable <= (w_cnt >= L_STABLE);
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/softmax_decision.sv
// Serial arg-max, threshold and stability over a softmax vector.
// Optional runner-up margin check: SOFTMAX_DECISION_MARGIN_EN.
module softmax_decision
    import nn_parameters::*;
#(
    parameter int N_CLASSES = NN_OUT_SIZE,
    parameter int PROB_W    = NN_PROB_W,
    parameter logic [PROB_W-1:0] CONF_THRESH = NN_CONF_THRESH,
    parameter int STABLE_CNT = NN_STABLE_CNT,
`ifdef SOFTMAX_DECISION_MARGIN_EN
    parameter logic [PROB_W-1:0] MARGIN = NN_MARGIN,
`endif
    parameter int ID_W = $clog2(N_CLASSES + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               prob_valid,
    output logic                               prob_ready,
    input  logic [N_CLASSES-1:0][PROB_W-1:0]   probabilities,
    output logic                               class_valid,
    input  logic                               class_ready,
    output logic [ID_W-1:0]                    class_id,
    output logic [PROB_W-1:0]                  class_conf,
    output logic                               class_reject,
    output logic                               class_stable
);

    localparam int IDX_W = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1;
    localparam logic [ID_W-1:0]  L_NO_CLASS = ID_W'(N_CLASSES);
    localparam logic [IDX_W-1:0] L_LAST     = IDX_W'(N_CLASSES - 1);

    state_t r_state;
    state_t w_next;

    logic [N_CLASSES-1:0][PROB_W-1:0] r_vec;
    logic [IDX_W-1:0]  r_idx;
    logic [PROB_W-1:0] r_best;
    logic [ID_W-1:0]   r_best_id;
    logic              r_valid;
    logic [ID_W-1:0]   r_id;
    logic [PROB_W-1:0] r_conf;
    logic              r_reject;
`ifdef SOFTMAX_DECISION_MARGIN_EN
    logic [PROB_W-1:0] r_second;
`endif

    logic [PROB_W-1:0] w_entry;
    logic              w_reject;
    logic              w_decide;

    assign w_entry  = r_vec[r_idx];
    assign w_decide = (r_state == S_DECIDE);

`ifdef SOFTMAX_DECISION_MARGIN_EN
    assign w_reject = (r_best < CONF_THRESH) ||
                      ((r_best - r_second) < MARGIN);
`else
    assign w_reject = (r_best < CONF_THRESH);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (prob_valid) w_next = S_SCAN;
            S_SCAN:   if (r_idx == L_LAST) w_next = S_DECIDE;
            S_DECIDE: w_next = S_OUT;
            S_OUT:    if (class_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Capture, serial arg-max scan and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec     <= '0;
            r_idx     <= '0;
            r_best    <= '0;
            r_best_id <= '0;
            r_valid   <= 1'b0;
            r_id      <= '0;
            r_conf    <= '0;
            r_reject  <= 1'b0;
`ifdef SOFTMAX_DECISION_MARGIN_EN
            r_second  <= '0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (prob_valid) begin
                        r_vec     <= probabilities;
                        r_idx     <= '0;
                        r_best    <= '0;
                        r_best_id <= '0;
`ifdef SOFTMAX_DECISION_MARGIN_EN
                        r_second  <= '0;
`endif
                    end
                end
                S_SCAN: begin
                    r_idx <= r_idx + 1'b1;
                    if (w_entry > r_best) begin
                        r_best    <= w_entry;
                        r_best_id <= ID_W'(r_idx);
`ifdef SOFTMAX_DECISION_MARGIN_EN
                        r_second  <= r_best;
                    end else if (w_entry > r_second) begin
                        r_second  <= w_entry;
`endif
                    end
                end
                S_DECIDE: begin
                    r_valid  <= 1'b1;
                    r_id     <= w_reject ? L_NO_CLASS : r_best_id;
                    r_conf   <= r_best;
                    r_reject <= w_reject;
                end
                S_OUT: begin
                    if (class_ready) r_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    decision_stability_filter #(
        .ID_W       (ID_W),
        .STABLE_CNT (STABLE_CNT),
        .NOCLS      (L_NO_CLASS)
    ) u_stab (
        .clk      (clk),
        .rst      (rst),
        .i_en     (w_decide),
        .i_reject (w_reject),
        .i_id     (r_best_id),
        .o_stable (class_stable)
    );

    assign prob_ready   = (r_state == S_IDLE);
    assign class_valid  = r_valid;
    assign class_id     = r_id;
    assign class_conf   = r_conf;
    assign class_reject = r_reject;

endmodule

// File: tb/tb_softmax_decision.sv
// Directed self-checking bench for softmax_decision.
// Expected values are hand-computed per vector.
module tb_softmax_decision;
    import nn_parameters::*;

    typedef logic [3:0][15:0] vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        prob_valid = 1'b0;
    logic        prob_ready;
    vec_t        probabilities = '0;
    logic        class_valid;
    logic        class_ready = 1'b1;
    logic [2:0]  class_id;
    prob_t       class_conf;
    logic        class_reject;
    logic        class_stable;

    int n_checks = 0;
    int n_fail   = 0;

    softmax_decision dut (
        .clk           (clk),
        .rst           (rst),
        .prob_valid    (prob_valid),
        .prob_ready    (prob_ready),
        .probabilities (probabilities),
        .class_valid   (class_valid),
        .class_ready   (class_ready),
        .class_id      (class_id),
        .class_conf    (class_conf),
        .class_reject  (class_reject),
        .class_stable  (class_stable)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] c, input logic [15:0] d);
        vec_t v;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake a vector; leaves us #1 after the handshake edge.
    task automatic start_vec(input vec_t v, input string tag);
        chk({tag, "_prdy"}, 32'(prob_ready), 32'd1);
        probabilities = v;
        prob_valid = 1'b1;
        tick();
        prob_valid = 1'b0;
    endtask

    // Cycle 1 is the cycle right after the handshake cycle.
    task automatic wait_valid(input string tag);
        int lat;
        lat = 1;
        while (!class_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'd6);
    endtask

    task automatic chk_out(input string tag, input logic [2:0] eid,
                           input logic [15:0] econf, input logic erej,
                           input logic estab);
        chk({tag, "_id"},   32'(class_id),     32'(eid));
        chk({tag, "_conf"}, 32'(class_conf),   32'(econf));
        chk({tag, "_rej"},  32'(class_reject), 32'(erej));
        chk({tag, "_stab"}, 32'(class_stable), 32'(estab));
    endtask

    task automatic run_vec(input vec_t v, input logic [2:0] eid,
                           input logic [15:0] econf, input logic erej,
                           input logic estab, input string tag);
        start_vec(v, tag);
        chk({tag, "_prdy_busy"}, 32'(prob_ready), 32'd0);
        wait_valid(tag);
        chk_out(tag, eid, econf, erej, estab);
        tick();
        chk({tag, "_vld_clr"}, 32'(class_valid), 32'd0);
        chk({tag, "_prdy_back"}, 32'(prob_ready), 32'd1);
    endtask

    vec_t vc;
    logic seen;

    initial begin
        vc = mk(16'h1000, 16'h2000, 16'h8000, 16'h0000);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_prdy", 32'(prob_ready),   32'd1);
        chk("rst_vld",  32'(class_valid),  32'd0);
        chk_out("rst", 3'd0, 16'h0, 1'b0, 1'b0);
        tick();

        run_vec(mk(16'd100, 16'h9000, 16'h2000, 16'd50),
                3'd1, 16'h9000, 1'b0, 1'b0, "basic");
        run_vec(mk(16'h3000, 16'h1000, 16'h0800, 16'h0100),
                3'd4, 16'h3000, 1'b1, 1'b0, "thr_rej");

        run_vec(vc, 3'd2, 16'h8000, 1'b0, 1'b0, "stab1");
        run_vec(vc, 3'd2, 16'h8000, 1'b0, 1'b0, "stab2");
        run_vec(vc, 3'd2, 16'h8000, 1'b0, 1'b1, "stab3");
        run_vec(vc, 3'd2, 16'h8000, 1'b0, 1'b1, "stab4");
        run_vec(mk(16'h7000, 16'h0000, 16'h0000, 16'h6000),
                3'd0, 16'h7000, 1'b0, 1'b0, "stab_chg");

        run_vec(mk(16'h0, 16'h0, 16'h0, 16'h0),
                3'd4, 16'h0, 1'b1, 1'b0, "zero");
        run_vec(mk(16'h0000, 16'h4000, 16'h0000, 16'h1000),
                3'd1, 16'h4000, 1'b0, 1'b0, "thr_eq");
        run_vec(mk(16'h3FFF, 16'h0000, 16'h0000, 16'h0000),
                3'd4, 16'h3FFF, 1'b1, 1'b0, "thr_m1");
`ifdef SOFTMAX_DECISION_MARGIN_EN
        run_vec(mk(16'h8000, 16'h8000, 16'h0000, 16'h0000),
                3'd4, 16'h8000, 1'b1, 1'b0, "tie");
`else
        run_vec(mk(16'h8000, 16'h8000, 16'h0000, 16'h0000),
                3'd0, 16'h8000, 1'b0, 1'b0, "tie");
`endif

        class_ready = 1'b0;
        start_vec(mk(16'h0, 16'h0, 16'h0, 16'h5000), "bp");
        wait_valid("bp");
        chk_out("bp", 3'd3, 16'h5000, 1'b0, 1'b0);
        probabilities = mk(16'hF000, 16'h0, 16'h0, 16'h0);
        prob_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold",
                {12'd0, class_valid, prob_ready, class_reject,
                 class_id, class_conf},
                {12'd0, 1'b1, 1'b0, 1'b0, 3'd3, 16'h5000});
        end
        class_ready = 1'b1;
        tick();
        prob_valid = 1'b0;
        chk("bp_rel_vld",  32'(class_valid), 32'd0);
        chk("bp_rel_prdy", 32'(prob_ready),  32'd1);
        chk("bp_keep_id",  32'(class_id),    32'd3);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (class_valid) seen = 1'b1;
        end
        chk("bp_no_ghost", 32'(seen), 32'd0);

        run_vec(vc, 3'd2, 16'h8000, 1'b0, 1'b0, "pre1");
        run_vec(vc, 3'd2, 16'h8000, 1'b0, 1'b0, "pre2");
        start_vec(vc, "abort");
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_prdy", 32'(prob_ready),  32'd1);
        chk("abort_vld",  32'(class_valid), 32'd0);
        chk_out("abort", 3'd0, 16'h0, 1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (class_valid) seen = 1'b1;
        end
        chk("abort_no_out", 32'(seen), 32'd0);
        run_vec(vc, 3'd2, 16'h8000, 1'b0, 1'b0, "post1");
        run_vec(vc, 3'd2, 16'h8000, 1'b0, 1'b0, "post2");
        run_vec(vc, 3'd2, 16'h8000, 1'b0, 1'b1, "post3");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
